// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling constants and the
// receiver/transmitter state type.
package uart_pkg;

  localparam int OVERSAMPLE = 8;
  localparam int MID_TICK   = 4;
  localparam int TICK_W     = $clog2(OVERSAMPLE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // A zero divider would never tick; treat it as one.
  function automatic logic [15:0] eff_prescale(
    input logic [15:0] p
  );
    return (p == 16'd0) ? 16'd1 : p;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for an asynchronous input,
// with a configurable depth and reset value.
module sync_ff #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic arstn,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_q;

  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) r_q <= RST_VAL;
        else        r_q <= i_d;
      end
    end else begin : g_many
      always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) r_q <= {DEPTH{RST_VAL}};
        else        r_q <= {r_q[DEPTH-2:0], i_d};
      end
    end
  endgenerate

  assign o_q = r_q[DEPTH-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8x oversampled, LSB first, one stop bit,
// AXI-stream style output with frame and overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  rxd,
  input  logic [15:0]           prescale,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  frame_error,
  output logic                  overrun_error
);

  localparam int BW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT =
    BW'(DATA_WIDTH - 1);
  localparam logic [TICK_W-1:0] MID_T =
    TICK_W'(MID_TICK - 1);
  localparam logic [TICK_W-1:0] END_T =
    TICK_W'(OVERSAMPLE - 1);

  logic                  w_line;
  logic [15:0]           w_pre;
  logic                  w_tick;
  logic                  w_stop_tick;
  logic                  w_load;
  logic                  w_xfer;
  logic [DATA_WIDTH-1:0] w_shift;

  uart_state_e           r_state;
  logic [15:0]           r_cnt;
  logic [TICK_W-1:0]     r_tcnt;
  logic [BW-1:0]         r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_armed;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tvalid;
  logic                  r_ferr;
  logic                  r_oerr;

  sync_ff #(
    .DEPTH   (2),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .arstn (arstn),
    .i_d   (rxd),
    .o_q   (w_line)
  );

  assign w_pre  = eff_prescale(prescale);
  // >= so a mid-frame shrink of prescale still ticks
  assign w_tick = (r_cnt >= w_pre - 16'd1);

  assign w_stop_tick = (r_state == ST_STOP) && w_tick
                    && (r_tcnt == END_T);
  assign w_load  = w_stop_tick && w_line;
  assign w_xfer  = r_tvalid && m_axis_tready;
  assign w_shift = (r_shift >> 1)
                 | (DATA_WIDTH'(w_line) << (DATA_WIDTH - 1));

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_tick ? 16'd0 : r_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state <= ST_IDLE;
      r_tcnt  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_armed <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_tcnt <= '0;
          r_bit  <= '0;
          if (w_line)       r_armed <= 1'b1;
          else if (r_armed) r_state <= ST_START;
        end
        ST_START: begin
          if (w_tick) begin
            if (r_tcnt == MID_T) begin
              r_tcnt  <= '0;
              r_state <= w_line ? ST_IDLE : ST_DATA;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_tcnt == END_T) begin
              r_tcnt  <= '0;
              r_shift <= w_shift;
              r_bit   <= r_bit + 1'b1;
              if (r_bit == LAST_BIT) r_state <= ST_STOP;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            if (r_tcnt == END_T) begin
              r_tcnt  <= '0;
              r_state <= ST_IDLE;
              // a low stop (break) must clear before re-arming
              if (!w_line) r_armed <= 1'b0;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_ferr   <= 1'b0;
      r_oerr   <= 1'b0;
    end else begin
      r_ferr <= w_stop_tick && !w_line;
      r_oerr <= w_load && r_tvalid && !m_axis_tready;
      if (w_load) begin
        r_tdata  <= r_shift;
        r_tvalid <= 1'b1;
      end else if (w_xfer) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign busy          = (r_state != ST_IDLE);
  assign frame_error   = r_ferr;
  assign overrun_error = r_oerr;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame driver feeding an expected-byte
// queue, negedge monitor popping and comparing deliveries.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        rxd = 1'b1;
  logic [15:0] prescale = 16'd4;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready = 1'b0;
  logic        busy;
  logic        ferr;
  logic        oerr;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .clk           (clk),
    .arstn         (arstn),
    .rxd           (rxd),
    .prescale      (prescale),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .busy          (busy),
    .frame_error   (ferr),
    .overrun_error (oerr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = -1;
  int exp_ferr = 0, exp_oerr = 0;
  int got_ferr = 0, got_oerr = 0;
  int busy_run = 0, busy_max = 0;
  int rdy_mode = 0;
  int low_run = 0;
  bit hold_mode = 0;
  logic [7:0] exp_q[$];
  logic       p_valid = 1'b0;
  logic       p_ready = 1'b0;
  logic [7:0] p_data = 8'h00;

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h",
                  nm, act, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // monitor
  initial forever begin
    @(negedge clk);
    if (arstn) begin
      if (ferr) got_ferr++;
      if (oerr) got_oerr++;
      if (busy) begin
        busy_run++;
        if (busy_run > busy_max) busy_max = busy_run;
      end else begin
        busy_run = 0;
      end
      if (tvalid && !p_valid) rise_cyc = cyc;
      if (p_valid && !p_ready && tvalid && !oerr)
        chk("hold_stable", tdata, p_data);
      if (tvalid && tready) begin
        chk("byte_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("tdata", tdata, exp_q.pop_front());
      end
    end
    p_valid = tvalid;
    p_ready = tready;
    p_data  = tdata;
  end

  // random tready, never low for more than 3 cycles
  initial forever begin
    @(posedge clk);
    #2;
    if (rdy_mode == 1) begin
      tready = ($urandom_range(0, 1) == 1) || (low_run >= 3);
      low_run = tready ? 0 : low_run + 1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input bit stop,
                            input int gap);
    int bclk;
    bclk = 8 * ((prescale == 16'd0) ? 1 : int'(prescale));
    if (stop) begin
      if (hold_mode && exp_q.size() > 0) begin
        exp_q[exp_q.size()-1] = d;
        exp_oerr++;
      end else begin
        exp_q.push_back(d);
      end
    end else begin
      exp_ferr++;
    end
    start_cyc = cyc;
    rxd = 1'b0;
    wait_clks(bclk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      wait_clks(bclk);
    end
    rxd = stop;
    wait_clks(bclk);
    rxd = 1'b1;
    if (gap > 0) wait_clks(gap);
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    wait_clks(4);
    chk({nm, "_drain"}, exp_q.size(), 0);
    chk({nm, "_ferr_cnt"}, got_ferr, exp_ferr);
    chk({nm, "_oerr_cnt"}, got_oerr, exp_oerr);
  endtask

  initial begin
    int lat;
    logic [7:0] d;
    bit st;
    repeat (3) @(negedge clk);
    chk("rst_tdata", tdata, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_oerr", oerr, 0);
    wait_clks(1);
    arstn = 1'b1;
    wait_clks(5);

    tready = 1'b1;
    rise_cyc = -1;
    send_frame(8'hA5, 1'b1, 64);
    lat = rise_cyc - start_cyc;
    chk("a5_latency_window", (lat >= 296 && lat <= 312), 1);
    drain("a5");

    tready = 1'b0;
    hold_mode = 1'b1;
    send_frame(8'h11, 1'b1, 16);
    send_frame(8'h22, 1'b1, 64);
    chk("ovr_tvalid_held", tvalid, 1);
    chk("ovr_tdata", tdata, exp_q[0]);
    hold_mode = 1'b0;
    tready = 1'b1;
    drain("ovr");

    busy_max = 0;
    rxd = 1'b0;
    wait_clks(10);
    rxd = 1'b1;
    wait_clks(100);
    chk("glitch_busy_1_to_20",
        (busy_max >= 1 && busy_max <= 20), 1);
    drain("glitch");

    send_frame(8'h3C, 1'b0, 64);
    chk("ferr_tvalid_low", tvalid, 0);
    drain("ferr");

    rxd = 1'b0;
    wait_clks(32);
    for (int i = 0; i < 3; i++) begin
      rxd = 1'b1;
      wait_clks(32);
    end
    wait_clks(16);
    chk("pre_reset_busy", busy, 1);
    arstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_tdata", tdata, 0);
    chk("mid_rst_tvalid", tvalid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_errs", {ferr, oerr}, 0);
    wait_clks(5);
    arstn = 1'b1;
    wait_clks(10);
    send_frame(8'h5A, 1'b1, 64);
    drain("rst");

    prescale = 16'd0;
    send_frame(8'h81, 1'b1, 16);
    drain("p0");

    rdy_mode = 1;
    for (int k = 0; k < 24; k++) begin
      prescale = 16'($urandom_range(0, 3));
      d = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 9) != 0);
      send_frame(d, st, st ? 0 : 40);
    end
    wait_clks(20);
    rdy_mode = 0;
    tready = 1'b1;
    drain("rand");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the number of data bits per character (frame format 8N1 when 8).
REQ-002 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-003 SHALL have port arstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port rxd  input  1  asynchronous serial line; idles high.
REQ-005 SHALL have port prescale  input  16  clk cycles per 1/8 bit period (clk_freq / (8*baud)).
REQ-006 SHALL have port m_axis_tdata  output  DATA_WIDTH  received character.
REQ-007 SHALL have port m_axis_tvalid  output  1  character available.
REQ-008 SHALL have port m_axis_tready  input  1  downstream accepts the character.
REQ-009 SHALL have port busy  output  1  a frame is in progress.
REQ-010 SHALL have port frame_error  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 SHALL have port overrun_error  output  1  one-cycle pulse: new character completed while tvalid was still high.

Function
REQ-012 SHALL pass rxd through a 2-flop synchronizer (reset value 1) before any use; "line" below means the synchronizer output.
REQ-013 SHALL generate a tick every max(prescale,1) clk cycles; the tick counter SHALL restart on entry to START; prescale=0 SHALL behave as prescale=1.
REQ-014 SHALL implement the states IDLE, START, DATA, STOP.
REQ-015 IDLE: a low line SHALL move the block to START and assert busy on the next cycle.
REQ-016 START: on the 4th tick (mid start bit) the block SHALL move to DATA if the line is low; if the line is high it SHALL return to IDLE (false start), with no output and no error.
REQ-017 DATA: the block SHALL sample the line every 8 ticks, LSB first, into a DATA_WIDTH shift register; after DATA_WIDTH samples it SHALL move to STOP.
REQ-018 STOP: on the 8th tick the block SHALL sample the stop bit and return to IDLE.
- Stop bit = 1: load m_axis_tdata and set m_axis_tvalid on the next cycle.
- Stop bit = 0: pulse frame_error, discard the character, leave m_axis_tvalid/m_axis_tdata unchanged.
REQ-019 After a stop bit = 1 with m_axis_tvalid already high and m_axis_tready low in that cycle, the block SHALL overwrite m_axis_tdata, keep m_axis_tvalid high, and pulse overrun_error.
REQ-020 A transfer occurs when tvalid and tready are both high; the block SHALL clear m_axis_tvalid on the following cycle unless a new character loads in that same cycle, in which case tvalid SHALL stay high with the new data and no overrun.
REQ-021 m_axis_tdata SHALL be held stable while m_axis_tvalid is high and unaccepted, except on overrun (REQ-019).
REQ-022 busy SHALL deassert in the cycle IDLE is re-entered; a new start bit SHALL be detectable the cycle after.
REQ-023 Changes to prescale mid-frame SHALL take effect at the next tick boundary; no further guarantee is given.

Reset
REQ-024 On arstn low, the block SHALL immediately enter IDLE and clear the counters and shift register.
REQ-025 On arstn low: m_axis_tvalid=0, m_axis_tdata=0, busy=0, frame_error=0, overrun_error=0, synchronizer=1.
REQ-026 Reset mid-frame SHALL discard the partial character; after release, the block SHALL wait for the line to be high for at least one cycle before detecting a start bit.

Structure
REQ-027 The oversample factor (8), the mid-bit tick (4), and the state enum type SHALL live in a shared uart package used by the matching transmitter.
REQ-028 The 2-flop synchronizer SHALL be a separate sub-module named sync_ff (parameterized depth, reset value).
REQ-029 The block SHALL be usable as the receive half of the existing uart wrapper with no change to the wrapper ports.

Verification
REQ-030 prescale=4, 8N1 frame of 0xA5 -> m_axis_tdata=0xA5, tvalid high 1 cycle after the stop sample (~300 clk after the start edge), no errors.
REQ-031 prescale=4, tready held low, frames 0x11 then 0x22 -> tdata=0x22, one overrun_error pulse, tvalid stays high.
REQ-032 prescale=4, 10-clk low glitch on rxd -> no tvalid, no error, busy high for at most 20 cycles.
REQ-033 prescale=4, frame 0x3C with stop bit low -> one frame_error pulse, tvalid stays low.
REQ-034 arstn asserted at data bit 3 of 0xFF, then a clean 0x5A frame -> all outputs 0 during reset, then tdata=0x5A only.
REQ-035 prescale=0, frame 0x81 at 8-clk bit period -> tdata=0x81; tready toggling during back-to-back frames -> every byte delivered exactly once.
